reg_snapshot_monitor: RTL and testbench

//  Synthesizable successor to the cycle-count/register-dump bench logic. Mirrors the CPU

---
 rtl/reg_snapshot_monitor_if.sv | 27 ++
 rtl/reg_snapshot_monitor.sv | 114 +++++++++++
 tb/tb_reg_snapshot_monitor.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/reg_snapshot_monitor_if.sv
// Register-file write mirror and dump stream bundle for reg_snapshot_monitor.
// master = the monitor (takes writes, drives the stream); slave = CPU/sink side.
interface reg_snapshot_monitor_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [ADDR_W:0]   out_idx_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_last_o;

    modport master (
        input  wr_en_i, wr_addr_i, wr_data_i, out_ready_i,
        output out_valid_o, out_idx_o, out_data_o, out_last_o
    );

    modport slave (
        output wr_en_i, wr_addr_i, wr_data_i, out_ready_i,
        input  out_valid_o, out_idx_o, out_data_o, out_last_o
    );
endinterface

// File: rtl/reg_snapshot_monitor.sv
// Shadows the CPU register-file write port, counts cycles, and streams a frozen
// snapshot of r0..r[DUMP_REGS-1] on END_COUNT or halt. MON_CHECKSUM_EN appends an XOR beat.
module reg_snapshot_monitor #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned DUMP_REGS = 13,
    parameter int unsigned END_COUNT = 25,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 halt_i,
    reg_snapshot_monitor_if.master bus,
    output logic [CNT_W-1:0]     cycle_o,
    output logic                 done_o
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);
    localparam int unsigned IDX_W  = ADDR_W + 1;
`ifdef MON_CHECKSUM_EN
    localparam int unsigned LAST_IDX = DUMP_REGS;
`else
    localparam int unsigned LAST_IDX = DUMP_REGS - 1;
`endif

    typedef enum logic [1:0] {S_RUN, S_DUMP, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [IDX_W-1:0]  idx;
    logic              addr_ok;
    logic              wr_hit;
    logic              cycle_sat;
    logic              trigger;
    logic              xfer;
    logic              at_last;
`ifdef MON_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    // A power-of-two register file has no unreachable addresses to filter.
    if (NUM_REGS == (1 << ADDR_W)) begin : g_full_map
        assign addr_ok = 1'b1;
    end else begin : g_part_map
        assign addr_ok = (bus.wr_addr_i < ADDR_W'(NUM_REGS));
    end

    always_comb begin
        cycle_sat = (cycle_o == '1);
        wr_hit    = (state == S_RUN) && bus.wr_en_i && (bus.wr_addr_i != '0) && addr_ok;
        trigger   = (state == S_RUN) &&
                    (halt_i || (!cycle_sat && cycle_o == CNT_W'(END_COUNT - 1)));
        xfer      = (state == S_DUMP) && bus.out_ready_i;
        at_last   = (idx == IDX_W'(LAST_IDX));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (trigger) state_nxt = S_DUMP;
            S_DUMP:  if (xfer && at_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        bus.out_valid_o = (state == S_DUMP);
        bus.out_last_o  = (state == S_DUMP) && at_last;
        bus.out_idx_o   = idx;
        bus.out_data_o  = '0;
        done_o          = (state == S_DONE);
        if (state == S_DUMP) begin
`ifdef MON_CHECKSUM_EN
            if (idx == IDX_W'(DUMP_REGS))
                bus.out_data_o = csum;
            else
                bus.out_data_o = shadow[idx[ADDR_W-1:0]];
`else
            bus.out_data_o = shadow[idx[ADDR_W-1:0]];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            state <= S_RUN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cycle_o <= '0;
            idx     <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++)
                shadow[i] <= '0;
`ifdef MON_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            if (state == S_RUN && !cycle_sat)
                cycle_o <= cycle_o + 1'b1;
            if (wr_hit)
                shadow[bus.wr_addr_i] <= bus.wr_data_i;
            if (xfer && !at_last)
                idx <= idx + 1'b1;
`ifdef MON_CHECKSUM_EN
            // Every non-final beat is a register word, so fold it in as it leaves.
            if (xfer && !at_last)
                csum <= csum ^ bus.out_data_o;
`endif
        end
    end
endmodule

// File: tb/tb_reg_snapshot_monitor.sv
// Randomized bench for reg_snapshot_monitor against a snapshot/queue reference model.
// NUM_REGS is 24 so that out-of-range write addresses are representable.
module tb_reg_snapshot_monitor;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_REGS  = 24;
    localparam int unsigned DUMP_REGS = 13;
    localparam int unsigned END_COUNT = 25;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned ADDR_W    = $clog2(NUM_REGS);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             halt;
    logic [CNT_W-1:0] cycle;
    logic             done;

    reg_snapshot_monitor_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) bus ();

    reg_snapshot_monitor #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .DUMP_REGS(DUMP_REGS),
        .END_COUNT(END_COUNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .halt_i (halt),
        .bus    (bus),
        .cycle_o(cycle),
        .done_o (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register contents, a cycle count, and the list of beats
    // captured at the trigger; ptr walks that list as beats are accepted.
    logic [DATA_W-1:0] m_sh [NUM_REGS];
    logic [DATA_W-1:0] m_beats [$];
    int                m_cyc;
    int                m_mode;   // 0 counting, 1 dumping, 2 finished
    int                m_ptr;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit we, input logic [ADDR_W-1:0] wa,
                              input logic [DATA_W-1:0] wd, input bit h, input bit rdy);
        logic [DATA_W-1:0] x;
        if (!r) begin
            foreach (m_sh[i]) m_sh[i] = '0;
            m_beats.delete();
            m_cyc  = 0;
            m_mode = 0;
            m_ptr  = 0;
        end else if (m_mode == 0) begin
            if (we && wa != 0 && int'(wa) < NUM_REGS) m_sh[wa] = wd;
            if (m_cyc < (1 << CNT_W) - 1) m_cyc++;
            if (m_cyc == END_COUNT || h) begin
                x = '0;
                m_beats.delete();
                for (int i = 0; i < DUMP_REGS; i++) begin
                    m_beats.push_back(m_sh[i]);
                    x ^= m_sh[i];
                end
`ifdef MON_CHECKSUM_EN
                m_beats.push_back(x);
`endif
                m_ptr  = 0;
                m_mode = 1;
            end
        end else if (m_mode == 1 && rdy) begin
            m_ptr++;
            if (m_ptr == m_beats.size()) m_mode = 2;
        end
    endtask

    task automatic compare_outputs();
        check("valid", bus.out_valid_o, m_mode == 1);
        check("done", done, m_mode == 2);
        check("cycle", cycle, m_cyc);
        if (m_mode == 1) begin
            check("idx", bus.out_idx_o, m_ptr);
            check("data", bus.out_data_o, m_beats[m_ptr]);
            check("last", bus.out_last_o, m_ptr == m_beats.size() - 1);
        end else begin
            check("last_idle", bus.out_last_o, 1'b0);
        end
    endtask

    task automatic tick(input bit r, input bit we, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] wd, input bit h, input bit rdy);
        @(negedge clk);
        rst_n           = r;
        bus.wr_en_i     = we;
        bus.wr_addr_i   = wa;
        bus.wr_data_i   = wd;
        halt            = h;
        bus.out_ready_i = rdy;
        @(posedge clk);
        model_step(r, we, wa, wd, h, rdy);
        #1;
        compare_outputs();
    endtask

    // halt_at < 0: no halt; rst_beat < 0: no mid-dump reset; directed: fixed writes.
    task automatic run_case(input int halt_at, input int rst_beat, input int ready_pct,
                            input bit directed);
        bit                we, h, rdy, r, did_rst;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        did_rst = 1'b0;
        tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("rst_idx", bus.out_idx_o, 0);
        check("rst_data", bus.out_data_o, 0);
        for (int c = 0; c < 300; c++) begin
            we  = ($urandom_range(0, 1) == 1);
            wa  = ADDR_W'($urandom_range(0, 31));
            wd  = $urandom;
            if (directed) begin
                we = 1'b0;
                case (m_cyc)
                    0: begin we = 1'b1; wa = 5'd0;  wd = 99; end
                    1: begin we = 1'b1; wa = 5'd1;  wd = 5;  end
                    2: begin we = 1'b1; wa = 5'd2;  wd = 7;  end
                    3: begin we = 1'b1; wa = 5'd3;  wd = 12; end
                    4: begin we = 1'b1; wa = 5'd28; wd = 77; end
                    END_COUNT - 1: begin we = 1'b1; wa = 5'd5; wd = 3; end
                    default: ;
                endcase
                if (m_mode == 1) begin we = 1'b1; wa = 5'd5; wd = 9; end
            end
            h   = (halt_at >= 0) && (m_cyc + 1 >= halt_at);
            rdy = ($urandom_range(0, 99) < ready_pct);
            r   = 1'b1;
            if (rst_beat >= 0 && !did_rst && m_mode == 1 && m_ptr == rst_beat) begin
                r       = 1'b0;
                did_rst = 1'b1;
            end
            tick(r, we, wa, wd, h, rdy);
        end
        check("finished", done, 1'b1);
    endtask

    initial begin
        rst_n           = 1'b0;
        halt            = 1'b0;
        bus.wr_en_i     = 1'b0;
        bus.wr_addr_i   = '0;
        bus.wr_data_i   = '0;
        bus.out_ready_i = 1'b1;

        run_case(-1, -1, 100, 1'b1);
        run_case(-1, -1, 45, 1'b1);
        run_case(6, -1, 100, 1'b0);
        run_case(-1, -1, 50, 1'b0);
        run_case(-1, 4, 80, 1'b0);
        run_case(END_COUNT, -1, 60, 1'b0);
        run_case(1, -1, 70, 1'b0);
        for (int k = 0; k < 5; k++)
            run_case(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 35)) : -1,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DUMP_REGS - 1)) : -1,
                     int'($urandom_range(30, 100)), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
